// File: rtl/demux1to4by32_buf.sv
// demux1to4by32_buf: routes one upstream valid/ready stream to four
// independent 2-entry FIFOs selected by in_addr. Each channel presents its
// oldest word from storage registers (no same-cycle pass-through), so a word
// becomes visible on the output one clock after it is pushed.
module demux1to4by32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_addr,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [7:0]       out_count
);

    // Occupancy level that marks a channel as full; pointers are single bits,
    // so only a depth of two is meaningful.
    localparam logic [1:0] FULL_LVL = 2'(DEPTH);

    // Per-channel storage, read/write pointers and occupancy.
    logic [3:0][1:0][WIDTH-1:0] mem_q, mem_d;
    logic [3:0]                 rd_q, rd_d;
    logic [3:0]                 wr_q, wr_d;
    logic [3:0][1:0]            cnt_q, cnt_d;

    logic [3:0] full_s;
    logic [3:0] push_s;
    logic [3:0] pop_s;

    // Status flags derived only from registered occupancy.
    always_comb begin
        full_s    = 4'b0000;
        out_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            full_s[k]    = (cnt_q[k] == FULL_LVL);
            out_valid[k] = (cnt_q[k] != 2'd0);
        end
    end

    // Ready reflects only the addressed channel, independent of in_valid and
    // any pop that may happen this cycle.
    assign in_ready = ~full_s[in_addr];

    // Push/pop decode and next-state for every channel.
    always_comb begin
        push_s = 4'b0000;
        pop_s  = 4'b0000;
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < 4; k++) begin
            push_s[k] = in_valid && in_ready && (in_addr == 2'(k));
            pop_s[k]  = out_valid[k] && out_ready[k];

            case ({push_s[k], pop_s[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
                2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
                default: cnt_d[k] = cnt_q[k];
            endcase

            // Storage is written only on an accepted push, so idle garbage on
            // in_data never reaches an entry.
            if (push_s[k]) begin
                mem_d[k][wr_q[k]] = in_data;
                wr_d[k]           = ~wr_q[k];
            end else begin
                wr_d[k] = wr_q[k];
            end

            if (pop_s[k]) begin
                rd_d[k] = ~rd_q[k];
            end else begin
                rd_d[k] = rd_q[k];
            end
        end
    end

    // State registers; reset empties every channel and zeroes the storage so
    // the head outputs read 0 immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            rd_q  <= 4'b0000;
            wr_q  <= 4'b0000;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Head words come straight out of the storage registers.
    assign out_data0 = mem_q[0][rd_q[0]];
    assign out_data1 = mem_q[1][rd_q[1]];
    assign out_data2 = mem_q[2][rd_q[2]];
    assign out_data3 = mem_q[3][rd_q[3]];
    assign out_count = cnt_q;

endmodule

// File: tb/tb_demux1to4by32_buf.sv
// Scoreboard bench for demux1to4by32_buf: each channel is modelled as a plain
// queue of expected words; the driver appends accepted words and a monitor on
// the falling edge compares the DUT's visible state against the queues.
module tb_demux1to4by32_buf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_addr;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]  out_count;

    logic [31:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    demux1to4by32_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one FIFO queue per channel, capacity two.
    logic [31:0] exp_q [4][$];
    logic        pend_v;
    logic [1:0]  pend_a;
    logic [31:0] pend_d;
    logic        mon_en;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle of stimulus: commit the word accepted at this edge into the
    // model, then present new inputs and decide from the model whether they
    // will be accepted at the next edge.
    task automatic cyc(input logic v, input logic [1:0] a, input logic [31:0] d, input logic [3:0] r);
        @(posedge clk);
        if (pend_v) begin
            exp_q[pend_a].push_back(pend_d);
            pend_v = 1'b0;
        end
        #1;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        out_ready = r;
        if (v && exp_q[a].size() < 2) begin
            pend_v = 1'b1;
            pend_a = a;
            pend_d = d;
        end
    endtask

    // Monitor: compare visible state with the model, then retire the words
    // the consumer takes at the coming edge.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("in_ready", 64'(in_ready), 64'(exp_q[in_addr].size() < 2));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("count%0d", k), 64'(out_count[2*k +: 2]), 64'(exp_q[k].size()));
                chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    chk($sformatf("head%0d", k), 64'(od[k]), 64'(exp_q[k][0]));
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (out_ready[k] && exp_q[k].size() != 0) begin
                    void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 2'd2;
        in_data   = 32'h1234_5678;
        out_ready = 4'b0000;
        pend_v    = 1'b0;
        pend_a    = 2'd0;
        pend_d    = 32'h0;
        mon_en    = 1'b0;

        // Reset state: empty, zero data, ready high, no push while in reset.
        #2;
        chk("rst_valid", 64'(out_valid), 64'(4'b0000));
        chk("rst_count", 64'(out_count), 64'(8'h00));
        chk("rst_data2", 64'(out_data2), 64'(32'h0));
        chk("rst_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;

        // Single push into channel 2 shows up one cycle later.
        cyc(1'b1, 2'd2, 32'hDEAD_0001, 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t28_valid", 64'(out_valid), 64'(4'b0100));
        chk("t28_data2", 64'(out_data2), 64'(32'hDEAD_0001));
        chk("t28_count", 64'(out_count), 64'(8'h10));
        cyc(1'b0, 2'd0, 32'h0, 4'b0100);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);

        // Channel 1 fills, third word waits until a pop frees a slot.
        cyc(1'b1, 2'd1, 32'hAAAA_0001, 4'b0000);
        cyc(1'b1, 2'd1, 32'hBBBB_0002, 4'b0000);
        cyc(1'b1, 2'd1, 32'hCCCC_0003, 4'b0000);
        @(negedge clk);
        chk("t29_full_rdy", 64'(in_ready), 64'(1'b0));
        chk("t29_count1", 64'(out_count[3:2]), 64'(2'd2));
        cyc(1'b1, 2'd1, 32'hCCCC_0003, 4'b0010);
        cyc(1'b1, 2'd1, 32'hCCCC_0003, 4'b0010);
        @(negedge clk);
        chk("t29_headB", 64'(out_data1), 64'(32'hBBBB_0002));
        chk("t29_rdy_after_pop", 64'(in_ready), 64'(1'b1));
        cyc(1'b0, 2'd0, 32'h0, 4'b0010);
        @(negedge clk);
        chk("t29_headC", 64'(out_data1), 64'(32'hCCCC_0003));
        cyc(1'b0, 2'd0, 32'h0, 4'b0010);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);

        // A full channel 0 does not block channel 3.
        cyc(1'b1, 2'd0, 32'h0000_00A0, 4'b0000);
        cyc(1'b1, 2'd0, 32'h0000_00A1, 4'b0000);
        cyc(1'b1, 2'd3, 32'h0000_0003, 4'b0000);
        @(negedge clk);
        chk("t30_ready", 64'(in_ready), 64'(1'b1));
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t30_count", 64'(out_count), 64'(8'h42));
        chk("t30_data3", 64'(out_data3), 64'(32'h0000_0003));
        chk("t30_data0", 64'(out_data0), 64'(32'h0000_00A0));
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'h0, 4'b1001);

        // Push and pop together on a channel holding one word.
        cyc(1'b1, 2'd2, 32'h2222_0001, 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t31_count_pre", 64'(out_count[5:4]), 64'(2'd1));
        cyc(1'b1, 2'd2, 32'h2222_0002, 4'b0100);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t31_count", 64'(out_count[5:4]), 64'(2'd1));
        chk("t31_data2", 64'(out_data2), 64'(32'h2222_0002));
        cyc(1'b0, 2'd0, 32'h0, 4'b0100);

        // Fill everything, then reset mid-stream.
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'(i / 2), 32'h5000_0000 + 32'(i), 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t32_full_count", 64'(out_count), 64'(8'hAA));
        @(posedge clk);
        #3;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 2'd0;
        in_data  = 32'hBAD0_BAD0;
        #1;
        chk("t32_valid", 64'(out_valid), 64'(4'b0000));
        chk("t32_count", 64'(out_count), 64'(8'h00));
        chk("t32_data", 64'({out_data0, out_data1} | {out_data2, out_data3}), 64'(0));
        chk("t32_ready", 64'(in_ready), 64'(1'b1));
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        pend_v = 1'b0;
        @(posedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        cyc(1'b1, 2'd0, 32'h0000_0032, 4'b0000);
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t32_post_valid", 64'(out_valid), 64'(4'b0001));
        chk("t32_post_data0", 64'(out_data0), 64'(32'h0000_0032));
        cyc(1'b0, 2'd0, 32'h0, 4'b0001);

        // Random traffic with random consumers.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
        end
        cyc(1'b0, 2'd0, 32'h0, 4'b0000);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
